pc_seq_ctrl: RTL and testbench
==============================

# pc_seq_ctrl

Next-PC sequencer and write controller for the 32-bit program-counter register. It chooses each cycle's next PC from five sources: sequential, branch, jump, exception vector and exception return. It gates the PC register write enable with fetch-ready and pipeline stall. Redirects that arrive while the write is blocked are held until they can be applied. It sits between the decode/execute stages, the instruction-fetch interface and the PC register.

## Interface
- RESET_PC, 32'h0040_0000, PC value after reset; must match the PC register reset value
- EXC_VECTOR, 32'h8000_0180, exception entry address
- BOOT_CYCLES, 2, cycles after reset release with PC write held off (1..15)
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- pc_cur  in  32  current PC, from the PC register output
- fetch_ready  in  1  instruction memory can accept a new fetch this cycle
- stall  in  1  pipeline hazard stall
- br_taken  in  1  branch resolved taken this cycle
- br_target  in  32  branch target
- jmp_valid  in  1  jump/jr this cycle
- jmp_target  in  32  jump target
- exc_req  in  1  exception request
- eret  in  1  exception return
- pc_next  out  32  value to the PC register data input
- pc_wr_en  out  1  write enable to the PC register
- flush  out  1  kill younger in-flight instructions
- epc  out  32  exception PC, registered
- exl  out  1  exception level; set while in the handler

## Operation
- States:
  - BOOT: wait BOOT_CYCLES cycles, then go to RUN.
  - RUN: normal operation.
  - EXC: single cycle; handler entry settles.
- Source priority, highest first: exc_req (only when exl=0) > eret (only when exl=1) > jmp_valid > br_taken > sequential.
  - exc_req while exl=1 is ignored.
  - eret while exl=0 is ignored.
- Source values:
  - Sequential: pc_next = pc_cur + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
  - Exception: pc_next = EXC_VECTOR.
  - Exception return: pc_next = epc.
  - Jump and branch: pc_next = the corresponding target.
- Write condition: pc_wr_en = (state==RUN) & fetch_ready & ~stall.
- Pending register (valid bit, type, target):
  - When a redirect is requested in a cycle where pc_wr_en=0, it is latched at the clock edge.
  - A later request of strictly higher priority overwrites the pending entry. Equal or lower priority requests are dropped.
  - At the next pc_wr_en=1 cycle, the pending entry is compared with the current-cycle requests. The higher priority wins; on a tie, pending wins.
  - The pending valid bit clears on that write.
- Exception, when applied:
  - epc <= pc_cur.
  - exl <= 1.
  - Go to EXC for 1 cycle, with pc_wr_en=0.
  - Then return to RUN.
- eret, when applied: exl <= 0. epc is unchanged.
- flush = 1 in every cycle where pc_wr_en=1 and the winning source is not sequential.
- Reset (asynchronous; may occur mid-operation; takes effect immediately):
  - State goes to BOOT.
  - The pending entry and boot counter clear.
  - pc_wr_en=0, flush=0, epc=0, exl=0.
  - pc_next=RESET_PC while in BOOT.

## Timing
- pc_next, pc_wr_en and flush are combinational from state, the pending register and the current inputs. The PC register updates on the same rising edge, so the redirect latency is 0 cycles.
- epc, exl, state and the pending register update on the rising clk edge.
- After rst rises, pc_wr_en stays 0 for exactly BOOT_CYCLES edges. The first write is on edge BOOT_CYCLES+1.
- Exception entry: the PC takes EXC_VECTOR at edge N. Edge N+1 is the EXC cycle with no write. The next write can occur at edge N+2.
- While stall=1 or fetch_ready=0: no PC change and no flush. Pending entries accumulate per the priority rules.
- If exc_req and eret are both asserted: exl determines which one is eligible, so they never conflict.

## Test plan
- Reset then run, with fetch_ready=1, stall=0. Required: pc_wr_en=0 for 2 cycles, then the PC sequence 0x400000 → 0x400004 → 0x400008.
- Jump and branch in the same cycle at pc_cur=0x400010 (jmp_target=0x400100, br_target=0x400200). Required: pc_next=0x400100, flush=1 for 1 cycle.
- Branch during stall:
  - br_taken pulses with target 0x400040 while stall=1. Required: no write.
  - stall drops 3 cycles later. Required: pc_next=0x400040, flush=1; the following cycle returns to sequential.
- Exception at pc_cur=0x400020. Required: pc_next=0x80000180, epc=0x400020, exl=1, and one no-write EXC cycle. A second exc_req while exl=1 is ignored. eret then gives pc_next=0x400020 and exl=0.
- Wrap: with pc_cur=0xFFFFFFFC and sequential. Required: pc_next=0x00000000.
- Reset mid-operation with a pending jump and exl=1: assert rst low. Required: immediately pc_wr_en=0, exl=0, epc=0; after release, the pending jump is not applied and the PC restarts at 0x400000.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl
//   Next-PC sequencer and write controller for the 32-bit program counter.
//   Selects the next PC from sequential / branch / jump / exception vector /
//   exception return, gates the PC register write with fetch_ready and stall,
//   and holds redirects that arrive while the write is blocked until they can
//   be applied.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   pc_cur          current PC from the PC register
//   fetch_ready     instruction memory can accept a fetch this cycle
//   stall           pipeline hazard stall
//   br_taken/br_target, jmp_valid/jmp_target   control-flow redirects
//   exc_req, eret   exception request / exception return
//   pc_next         data input of the PC register
//   pc_wr_en        write enable of the PC register
//   flush           kill younger in-flight instructions
//   epc, exl        exception PC and exception level (registered)
// -----------------------------------------------------------------------------
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        fetch_ready,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] pc_next,
    output logic        pc_wr_en,
    output logic        flush,
    output logic [31:0] epc,
    output logic        exl
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_EXC} state_t;

    // Encoded so that a larger value means a higher priority source.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_ERET = 3'd3,
        SRC_EXC  = 3'd4
    } src_t;

    state_t      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic        pend_vld_q, pend_vld_d;
    src_t        pend_src_q, pend_src_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] epc_q, epc_d;
    logic        exl_q, exl_d;

    src_t        req_src;
    logic [31:0] req_tgt;
    src_t        win_src;
    logic [31:0] win_tgt;
    logic        wr_en;

    // Current-cycle request, with exc_req/eret gated by the exception level.
    always_comb begin
        req_src = SRC_SEQ;
        req_tgt = pc_cur + 32'd4;
        if (exc_req && !exl_q) begin
            req_src = SRC_EXC;
            req_tgt = EXC_VECTOR;
        end else if (eret && exl_q) begin
            req_src = SRC_ERET;
            req_tgt = epc_q;
        end else if (jmp_valid) begin
            req_src = SRC_JMP;
            req_tgt = jmp_target;
        end else if (br_taken) begin
            req_src = SRC_BR;
            req_tgt = br_target;
        end
    end

    // Pending entry wins ties against the current request.
    always_comb begin
        win_src = req_src;
        win_tgt = req_tgt;
        if (pend_vld_q && (pend_src_q >= req_src)) begin
            win_src = pend_src_q;
            win_tgt = pend_tgt_q;
        end
    end

    always_comb begin
        wr_en    = (state_q == ST_RUN) && fetch_ready && !stall;
        pc_wr_en = wr_en;
        flush    = wr_en && (win_src != SRC_SEQ);
        pc_next  = (state_q == ST_BOOT) ? RESET_PC : win_tgt;
        epc      = epc_q;
        exl      = exl_q;
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pend_vld_d = pend_vld_q;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        epc_d      = epc_q;
        exl_d      = exl_q;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (wr_en && (win_src == SRC_EXC)) begin
                    state_d = ST_EXC;
                end
            end
            ST_EXC:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (wr_en) begin
            pend_vld_d = 1'b0;
            if (win_src == SRC_EXC) begin
                epc_d = pc_cur;
                exl_d = 1'b1;
            end else if (win_src == SRC_ERET) begin
                exl_d = 1'b0;
            end
        end else if ((req_src != SRC_SEQ) &&
                     (!pend_vld_q || (req_src > pend_src_q))) begin
            // Blocked redirect: keep only the highest-priority one seen.
            pend_vld_d = 1'b1;
            pend_src_d = req_src;
            pend_tgt_d = req_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
            pend_vld_q <= 1'b0;
            pend_src_q <= SRC_SEQ;
            epc_q      <= 32'd0;
            exl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_src_q <= pend_src_d;
            epc_q      <= epc_d;
            exl_q      <= exl_d;
        end
    end

    // Target is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_ctrl
//   Self-checking bench for pc_seq_ctrl. The bench owns a model of the PC
//   register (loaded from pc_next on pc_wr_en, or preset by set_pc while the
//   pipeline is stalled). Each row drives one cycle of inputs and pushes the
//   required outputs to a queue; the entry is popped and compared at the
//   following falling edge.
//   mk() column order: fetch_ready, stall, br_taken, br_target, jmp_valid,
//   jmp_target, exc_req, eret | check_pc_next, pc_wr_en, flush, exl, epc,
//   pc_next
// -----------------------------------------------------------------------------
module tb_pc_seq_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam logic [31:0] EP         = 32'h0040_0020;

    typedef struct packed {
        logic        chk;
        logic        wr;
        logic        fl;
        logic        exl;
        logic [31:0] epc;
        logic [31:0] nxt;
    } exp_t;

    typedef struct packed {
        logic        fr;
        logic        st;
        logic        br;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic        ex;
        logic        er;
        exp_t        e;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        fetch_ready, stall, br_taken, jmp_valid, exc_req, eret;
    logic [31:0] br_target, jmp_target;
    logic [31:0] pc_next, epc;
    logic        pc_wr_en, flush, exl;

    logic        pc_ld;
    logic [31:0] pc_ld_val;
    logic [31:0] pc_reg;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_seq_ctrl #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR),
        .BOOT_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_cur     (pc_cur),
        .fetch_ready(fetch_ready),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .pc_next    (pc_next),
        .pc_wr_en   (pc_wr_en),
        .flush      (flush),
        .epc        (epc),
        .exl        (exl)
    );

    // PC register model
    always @(posedge clk or negedge rst) begin
        if (!rst)          pc_reg <= RESET_PC;
        else if (pc_ld)    pc_reg <= pc_ld_val;
        else if (pc_wr_en) pc_reg <= pc_next;
    end
    assign pc_cur = pc_reg;

    function automatic row_t mk(input logic fr, st, br, input logic [31:0] bt,
                                input logic jv, input logic [31:0] jt,
                                input logic ex, er, chk, wr, fl, xl,
                                input logic [31:0] ep, nx);
        row_t r;
        r.fr = fr; r.st = st; r.br = br; r.bt = bt; r.jv = jv; r.jt = jt;
        r.ex = ex; r.er = er;
        r.e.chk = chk; r.e.wr = wr; r.e.fl = fl; r.e.exl = xl;
        r.e.epc = ep;  r.e.nxt = nx;
        return r;
    endfunction

    task automatic set_idle();
        fetch_ready = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        jmp_valid = 1'b0; jmp_target = 32'h0; exc_req = 1'b0; eret = 1'b0;
    endtask

    task automatic drive_row(input row_t r);
        fetch_ready = r.fr; stall = r.st; br_taken = r.br; br_target = r.bt;
        jmp_valid = r.jv; jmp_target = r.jt; exc_req = r.ex; eret = r.er;
        exp_q.push_back(r.e);
    endtask

    // Presets the PC register during a stalled, request-free cycle.
    task automatic set_pc(input logic [31:0] v);
        set_idle();
        stall = 1'b1; pc_ld = 1'b1; pc_ld_val = v;
        @(posedge clk); #1;
        pc_ld = 1'b0;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        logic [66:0] got, want;
        rst = 1'b0; pc_ld = 1'b0; pc_ld_val = 32'h0;
        set_idle();
        repeat (2) @(negedge clk);
        checks++; if (pc_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b required 0", pc_wr_en); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b required 0", flush); end
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL reset_exl: got %b required 0", exl); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h required 0", epc); end
        checks++; if (pc_next !== RESET_PC) begin errors++; $display("FAIL reset_pc_next: got %h required %h", pc_next, RESET_PC); end
        rst = 1'b1; #1;
        checks++; if (pc_wr_en !== 1'b0) begin errors++; $display("FAIL boot_wr0: got %b required 0", pc_wr_en); end
        @(posedge clk); #1;
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0, RESET_PC));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,0, 32'h0040_0004));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,0, 32'h0040_0008));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL reset_run row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_branch();
        row_t rows[$];
        exp_t e;
        logic [66:0] got, want;
        set_pc(32'h0040_0010);
        rows.push_back(mk(1,0,1,32'h0040_0200,1,32'h0040_0100,0,0, 1,1,1,0,0, 32'h0040_0100));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,0, 32'h0040_0104));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL jump_branch row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_stall();
        row_t rows[$];
        exp_t e;
        logic [66:0] got, want;
        set_pc(32'h0040_0030);
        rows.push_back(mk(1,1,1,32'h0040_0040,0,0,0,0, 0,0,0,0,0, 0));
        rows.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,0,0, 0));
        rows.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,0,0, 0));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,1,0,0, 32'h0040_0040));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,0, 32'h0040_0044));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL branch_stall row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exception();
        row_t rows[$];
        exp_t e;
        logic [66:0] got, want;
        set_pc(32'h0040_0020);
        rows.push_back(mk(1,0,0,0,0,0,1,0, 1,1,1,0,0,  EXC_VECTOR));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,1,EP, 0));
        rows.push_back(mk(1,0,0,0,0,0,1,0, 1,1,0,1,EP, 32'h8000_0184));
        rows.push_back(mk(1,0,0,0,0,0,0,1, 1,1,1,1,EP, EP));
        rows.push_back(mk(1,0,0,0,0,0,0,1, 1,1,0,0,EP, 32'h0040_0024));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL exception row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        exp_t e;
        logic [66:0] got, want;
        set_pc(32'hFFFF_FFFC);
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,EP, 32'h0000_0000));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL wrap row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pending_priority();
        row_t rows[$];
        exp_t e;
        logic [66:0] got, want;
        set_pc(32'h0040_0050);
        rows.push_back(mk(1,1,1,32'h0040_0060,0,0,0,0, 0,0,0,0,EP, 0));
        rows.push_back(mk(1,1,0,0,1,32'h0040_0070,0,0, 0,0,0,0,EP, 0));
        rows.push_back(mk(1,1,1,32'h0040_0080,0,0,0,0, 0,0,0,0,EP, 0));
        rows.push_back(mk(1,0,1,32'h0040_0090,0,0,0,0, 1,1,1,0,EP, 32'h0040_0070));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,EP, 32'h0040_0074));
        rows.push_back(mk(0,0,0,0,1,32'h0040_0100,0,0, 0,0,0,0,EP, 0));
        rows.push_back(mk(1,0,0,0,1,32'h0040_0200,0,0, 1,1,1,0,EP, 32'h0040_0100));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,EP, 32'h0040_0104));
        rows.push_back(mk(1,1,1,32'h0040_0300,0,0,0,0, 0,0,0,0,EP, 0));
        rows.push_back(mk(1,0,0,0,1,32'h0040_0400,0,0, 1,1,1,0,EP, 32'h0040_0400));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,EP, 32'h0040_0404));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL pending row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        row_t post[$];
        exp_t e;
        logic [66:0] got, want;
        set_pc(32'h0040_0500);
        rows.push_back(mk(1,0,0,0,0,0,1,0, 1,1,1,0,EP, EXC_VECTOR));
        rows.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,1,32'h0040_0500, 0));
        rows.push_back(mk(1,1,0,0,1,32'h0040_0600,0,0, 0,0,0,1,32'h0040_0500, 0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL reset_mid_pre row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
        set_idle();
        #2 rst = 1'b0;
        #1;
        checks++; if (pc_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr: got %b required 0", pc_wr_en); end
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL mid_reset_exl: got %b required 0", exl); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL mid_reset_epc: got %h required 0", epc); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_reset_flush: got %b required 0", flush); end
        checks++; if (pc_next !== RESET_PC) begin errors++; $display("FAIL mid_reset_pc_next: got %h required %h", pc_next, RESET_PC); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        post.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0, RESET_PC));
        post.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,0, 32'h0040_0004));
        foreach (post[i]) begin
            drive_row(post[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got  = {pc_wr_en, flush, exl, epc, e.chk ? pc_next : 32'h0};
            want = {e.wr, e.fl, e.exl, e.epc, e.chk ? e.nxt : 32'h0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL reset_mid_post row %0d: got wr=%b fl=%b exl=%b epc=%h nxt=%h required wr=%b fl=%b exl=%b epc=%h nxt=%h", i, pc_wr_en, flush, exl, epc, pc_next, e.wr, e.fl, e.exl, e.epc, e.nxt); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_jump_branch();
        test_branch_stall();
        test_exception();
        test_wrap();
        test_pending_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
